// File: rtl/signal_gen_pkg.sv
// Shared types and default sizes for the tick-driven waveform generator.
package signal_gen_pkg;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'b00,
    WAVE_TRI  = 2'b01,
    WAVE_SQR  = 2'b10,
    WAVE_MUTE = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/signal_gen_en1m_if.sv
// Configuration valid/ready channel of the waveform generator.
interface signal_gen_en1m_if
  import signal_gen_pkg::*;
#(
  parameter int PHASE_W = signal_gen_pkg::PHASE_W
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_freq;
  wave_t              cfg_wave;

  modport master (output cfg_valid, output cfg_freq, output cfg_wave, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_freq, input cfg_wave, output cfg_ready);
endinterface

// File: rtl/signal_gen_shaper.sv
// Combinational phase-to-sample shaper: saw, triangle, square or mute.
module signal_gen_shaper
  import signal_gen_pkg::*;
#(
  parameter int PHASE_W  = signal_gen_pkg::PHASE_W,
  parameter int SAMPLE_W = signal_gen_pkg::SAMPLE_W
) (
  input  logic [PHASE_W-1:0]  phase,
  input  wave_t               wave,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int T = PHASE_W - 1;

  logic [SAMPLE_W-1:0] tri_lo;

  // Triangle folds the lower half-period bits around the top phase bit.
  assign tri_lo = phase[T-1 -: SAMPLE_W];

  always_comb begin
    sample = '0;
    unique case (wave)
      WAVE_SAW:  sample = phase[T -: SAMPLE_W];
      WAVE_TRI:  sample = phase[T] ? ~tri_lo : tri_lo;
      WAVE_SQR:  sample = {SAMPLE_W{phase[T]}};
      WAVE_MUTE: sample = '0;
      default:   sample = '0;
    endcase
  end

  generate
    if (PHASE_W > SAMPLE_W + 1) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^phase[T-SAMPLE_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/signal_gen_en1m.sv
// Phase-accumulator waveform generator advanced by the 1 MHz enable strobe;
// new configurations are queued and swapped in at the next phase wrap.
module signal_gen_en1m
  import signal_gen_pkg::*;
#(
  parameter int PHASE_W  = signal_gen_pkg::PHASE_W,
  parameter int SAMPLE_W = signal_gen_pkg::SAMPLE_W
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic                 en1m,
  signal_gen_en1m_if.slave     cfg,
  output logic [SAMPLE_W-1:0]  sample,
  output logic                 sample_valid,
  output logic                 sync
);

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  freq_q, freq_d;
  wave_t               wave_q, wave_d;
  logic [PHASE_W-1:0]  pend_freq_q, pend_freq_d;
  wave_t               pend_wave_q, pend_wave_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic                sync_q, sync_d;

  logic                ready;
  logic                accept;
  logic                carry;
  logic [PHASE_W-1:0]  sum;
  wave_t               shape_wave;
  logic [SAMPLE_W-1:0] shaped;

  assign ready         = (state_q != PEND);
  assign accept        = cfg.cfg_valid & ready;
  assign {carry, sum}  = {1'b0, phase_q} + {1'b0, freq_q};
  assign cfg.cfg_ready = ready;

  signal_gen_shaper #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_shaper (
    .phase  (phase_d),
    .wave   (shape_wave),
    .sample (shaped)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    freq_d         = freq_q;
    wave_d         = wave_q;
    pend_freq_d    = pend_freq_q;
    pend_wave_d    = pend_wave_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    sync_d         = 1'b0;
    shape_wave     = wave_q;

    unique case (state_q)
      IDLE: begin
        // Frequency is zero here, so a coincident tick still shapes phase 0.
        if (accept) begin
          freq_d  = cfg.cfg_freq;
          wave_d  = cfg.cfg_wave;
          state_d = (cfg.cfg_freq != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (en1m) phase_d = sum;
        if (accept) begin
          pend_freq_d = cfg.cfg_freq;
          pend_wave_d = cfg.cfg_wave;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (en1m) begin
          phase_d = sum;
          if (carry) begin
            freq_d     = pend_freq_q;
            wave_d     = pend_wave_q;
            shape_wave = pend_wave_q;
            if (pend_freq_q == '0) begin
              phase_d = '0;
              state_d = IDLE;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (en1m) begin
      sample_valid_d = 1'b1;
      sync_d         = carry;
      sample_d       = shaped;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      freq_q         <= '0;
      wave_q         <= WAVE_SAW;
      pend_freq_q    <= '0;
      pend_wave_q    <= WAVE_SAW;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sync_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      freq_q         <= freq_d;
      wave_q         <= wave_d;
      pend_freq_q    <= pend_freq_d;
      pend_wave_q    <= pend_wave_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sync_q         <= sync_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign sync         = sync_q;

endmodule

// File: tb/tb_signal_gen_en1m.sv
// Scoreboard bench for signal_gen_en1m: a reference model queues the expected
// sample/sync for every tick and a negedge monitor compares DUT output.
module tb_signal_gen_en1m;
  import signal_gen_pkg::*;

  typedef struct {
    logic [7:0] smp;
    logic       syn;
  } exp_t;

  logic       clk50m = 1'b0;
  logic       rst;
  logic       en1m;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sync;

  signal_gen_en1m_if #(.PHASE_W(16)) cfg_if ();

  signal_gen_en1m #(.PHASE_W(16), .SAMPLE_W(8)) dut (
    .clk50m       (clk50m),
    .rst          (rst),
    .en1m         (en1m),
    .cfg          (cfg_if),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sync         (sync)
  );

  always #10 clk50m = ~clk50m;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     done    = 1'b0;
  exp_t   exp_q[$];
  logic [7:0] last_exp = 8'h00;

  state_t m_state;
  int     m_phase, m_freq, m_pf;
  wave_t  m_wave, m_pw;

  task automatic check(string tag, int unsigned act, int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_shape(int p, wave_t w);
    int t;
    t = (p >> 7) & 255;
    case (w)
      WAVE_SAW: return 8'((p >> 8) & 255);
      WAVE_TRI: return (p >= 32768) ? 8'(255 - t) : 8'(t);
      WAVE_SQR: return (p >= 32768) ? 8'hFF : 8'h00;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic push(logic [7:0] s, logic y);
    exp_t e;
    e.smp = s;
    e.syn = y;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_phase = 0;
    m_freq  = 0;
    m_wave  = WAVE_SAW;
    m_pf    = 0;
    m_pw    = WAVE_SAW;
  endtask

  // One clock cycle: drive inputs, advance the model, check cfg_ready after the edge.
  task automatic step(bit en, bit cv, int f, wave_t w);
    bit acc;
    bit carry;
    int s;
    acc = cv && (m_state != PEND);
    en1m             = en;
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_freq  = f[15:0];
    cfg_if.cfg_wave  = w;
    s     = m_phase + m_freq;
    carry = (s > 65535);
    s     = s & 65535;
    case (m_state)
      IDLE: begin
        if (en) push(model_shape(0, m_wave), 1'b0);
        if (acc) begin
          m_freq  = f;
          m_wave  = w;
          m_state = (f != 0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (en) begin
          m_phase = s;
          push(model_shape(s, m_wave), carry);
        end
        if (acc) begin
          m_pf    = f;
          m_pw    = w;
          m_state = PEND;
        end
      end
      default: begin
        if (en) begin
          m_phase = s;
          if (carry) begin
            m_freq = m_pf;
            m_wave = m_pw;
            if (m_pf == 0) begin
              m_phase = 0;
              m_state = IDLE;
            end else begin
              m_state = RUN;
            end
          end
          push(model_shape(m_phase, m_wave), carry);
        end
      end
    endcase
    @(posedge clk50m);
    #1;
    check("cfg_ready", cfg_if.cfg_ready, (m_state != PEND) ? 1 : 0);
    en1m             = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic ticks(int n, bit spaced);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 0, WAVE_SAW);
      if (spaced) step(1'b0, 1'b0, 0, WAVE_SAW);
    end
  endtask

  always @(negedge clk50m) begin
    if (!rst && !done) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sample", sample, e.smp);
          check("sync", sync, e.syn);
          last_exp = e.smp;
        end
      end else begin
        check("sync_no_valid", sync, 0);
        check("sample_hold", sample, last_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    en1m             = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_freq  = '0;
    cfg_if.cfg_wave  = WAVE_SAW;
    model_reset();
    #25;
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_sync", sync, 0);
    check("reset_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;
    @(posedge clk50m);
    #1;

    // Idle ticks, then saw config accepted together with a tick.
    ticks(2, 1'b1);
    step(1'b1, 1'b1, 'h0100, WAVE_SAW);
    ticks(256, 1'b1);

    // Stop request queued; a second offer while pending must be refused.
    step(1'b0, 1'b1, 0, WAVE_SAW);
    step(1'b1, 1'b1, 'h3000, WAVE_TRI);
    ticks(258, 1'b0);

    // Triangle from IDLE.
    step(1'b0, 1'b1, 'h0800, WAVE_TRI);
    ticks(40, 1'b1);

    // Saw 0x1000 swapped in at the triangle wrap, then a mid-period square request.
    step(1'b0, 1'b1, 'h1000, WAVE_SAW);
    ticks(24, 1'b0);
    ticks(3, 1'b1);
    step(1'b0, 1'b1, 'h2000, WAVE_SQR);
    ticks(30, 1'b1);

    // Stop, then back-to-back ticks with config coincident with a wrap.
    step(1'b0, 1'b1, 0, WAVE_MUTE);
    ticks(20, 1'b0);
    step(1'b0, 1'b1, 'h4000, WAVE_SAW);
    ticks(3, 1'b0);
    step(1'b1, 1'b1, 'h1000, WAVE_TRI);
    ticks(4, 1'b0);
    ticks(5, 1'b0);

    // Asynchronous reset while a config is pending.
    step(1'b0, 1'b1, 'h0800, WAVE_SQR);
    ticks(2, 1'b1);
    #5;
    rst = 1'b1;
    #1;
    check("midrst_sample", sample, 0);
    check("midrst_valid", sample_valid, 0);
    check("midrst_sync", sync, 0);
    check("midrst_ready", cfg_if.cfg_ready, 1);
    model_reset();
    exp_q.delete();
    last_exp = 8'h00;
    #1;
    rst = 1'b0;
    @(posedge clk50m);
    #1;
    ticks(3, 1'b1);

    @(posedge clk50m);
    #1;
    check("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
